// File: rtl/pipe_alu_pkg.sv
// Shared types for pipe_alu: opcode encoding, flag bundle and shift-amount width helper.
package pipe_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

  localparam int FLAGS_W = $bits(flags_t);

  function automatic int clog2(input int value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/pipe_alu_stage.sv
// One pipeline register slice: valid bit plus payload, loaded when advance_i is high.
module pipe_alu_stage #(
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance_i,
  input  logic          valid_i,
  input  logic [PW-1:0] data_i,
  output logic          valid_o,
  output logic [PW-1:0] data_o
);

  logic          valid_d, valid_q;
  logic [PW-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (advance_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // predecessor's pre-edge value; blocking here would shoot data through all stages at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset too, so result and flags read zero after reset,
      // not just the valid bit.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_alu.sv
// Pipelined ALU with valid/ready backpressure. Define PIPE_ALU_FLAGS_EN to add the
// zero/carry/overflow flag outputs and their pipeline bits.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef PIPE_ALU_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
`endif
);

  localparam int SHW = clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
`ifdef PIPE_ALU_FLAGS_EN
  localparam int PW = WIDTH + FLAGS_W;
`else
  localparam int PW = WIDTH;
`endif

  op_e              op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic [PW-1:0]    payload;

  assign op      = op_e'(op_code);
  assign shamt   = operand_b[SHW-1:0];
  assign sub_res = operand_a - operand_b;

`ifdef PIPE_ALU_FLAGS_EN
  logic   carry_add;
  flags_t alu_flags;
  assign {carry_add, add_res} = {1'b0, operand_a} + {1'b0, operand_b};
`else
  assign add_res = operand_a + operand_b;
`endif

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD: alu_res = add_res;
      OP_SUB: alu_res = sub_res;
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_XOR: alu_res = operand_a ^ operand_b;
      OP_SLL: alu_res = operand_a << shamt;
      OP_SRL: alu_res = operand_a >> shamt;
      OP_SLT: alu_res[0] = $signed(operand_a) < $signed(operand_b);
      default: alu_res = '0;
    endcase
  end

`ifdef PIPE_ALU_FLAGS_EN
  always_comb begin
    alu_flags      = '0;
    alu_flags.zero = (alu_res == '0);
    if (op == OP_ADD) begin
      alu_flags.carry = carry_add;
      alu_flags.ovf   = (operand_a[MSB] == operand_b[MSB]) && (add_res[MSB] != operand_a[MSB]);
    end else if (op == OP_SUB) begin
      alu_flags.carry = operand_a < operand_b;
      alu_flags.ovf   = (operand_a[MSB] != operand_b[MSB]) && (sub_res[MSB] != operand_a[MSB]);
    end
  end
  assign payload = {alu_flags, alu_res};
`else
  assign payload = alu_res;
`endif

  // Element 0 is the compute output; element i+1 is the output of stage i.
  logic          vld_chain [0:STAGES];
  logic [PW-1:0] dat_chain [0:STAGES];
  logic [STAGES-1:0] advance;

  assign vld_chain[0] = in_valid;
  assign dat_chain[0] = payload;

  // Advance ripples back from the output so a bubble anywhere lets upstream move.
  always_comb begin
    advance = '0;
    advance[STAGES-1] = !vld_chain[STAGES] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      advance[i] = !vld_chain[i+1] || advance[i+1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_alu_stage #(.PW(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance_i (advance[g]),
      .valid_i   (vld_chain[g]),
      .data_i    (dat_chain[g]),
      .valid_o   (vld_chain[g+1]),
      .data_o    (dat_chain[g+1])
    );
  end

  assign in_ready  = advance[0];
  assign out_valid = vld_chain[STAGES];
  assign result    = dat_chain[STAGES][WIDTH-1:0];

`ifdef PIPE_ALU_FLAGS_EN
  flags_t out_flags;
  assign out_flags  = flags_t'(dat_chain[STAGES][WIDTH +: FLAGS_W]);
  assign flag_zero  = out_flags.zero;
  assign flag_carry = out_flags.carry;
  assign flag_ovf   = out_flags.ovf;
`endif

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: stimulus pushes expected results, a monitor pops them.
module tb_pipe_alu;
  import pipe_alu_pkg::*;

  localparam int STG = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit, 2-stage instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op_code;
  logic [31:0] operand_a, operand_b, result;
`ifdef PIPE_ALU_FLAGS_EN
  logic        flag_zero, flag_carry, flag_ovf;
`endif

  pipe_alu #(.WIDTH(32), .STAGES(STG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef PIPE_ALU_FLAGS_EN
    ,
    .flag_zero (flag_zero),
    .flag_carry(flag_carry),
    .flag_ovf  (flag_ovf)
`endif
  );

  // 8-bit, 4-stage instance
  logic       iv8, ir8, ov8;
  logic       or8;
  logic [2:0] op8;
  logic [7:0] a8, b8, r8;
`ifdef PIPE_ALU_FLAGS_EN
  logic       fz8, fc8, fo8;
`endif

  pipe_alu #(.WIDTH(8), .STAGES(4)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .op_code   (op8),
    .operand_a (a8),
    .operand_b (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .result    (r8)
`ifdef PIPE_ALU_FLAGS_EN
    ,
    .flag_zero (fz8),
    .flag_carry(fc8),
    .flag_ovf  (fo8)
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [2:0]  flg;  // {zero, carry, ovf}
    int          due;  // cycle the result must appear, -1 = unchecked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one op, wait (bounded) for acceptance, optionally record the expectation.
  task automatic send(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic [2:0] ef, input bit timed, input bit push);
    int n = 0;
    op_code   = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, in_ready, 1);
    if (push) sb.push_back('{tag, er, ef, timed ? cyc + STG : -1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  // Monitor: a transfer happens at the next edge whenever out_valid && out_ready now.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_result"}, result, e.res);
          if (e.due >= 0) check({e.tag, "_latency"}, cyc, e.due);
`ifdef PIPE_ALU_FLAGS_EN
          check({e.tag, "_flags"}, {flag_zero, flag_carry, flag_ovf}, e.flg);
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_code = '0; operand_a = '0; operand_b = '0;
    iv8 = 1'b0; or8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Legacy ops, back to back, each 2 cycles after presentation
    send("add", OP_ADD, 15, 10, 25, 3'b000, 1, 1);
    send("sub", OP_SUB, 25, 10, 15, 3'b000, 1, 1);
    send("and", OP_AND, 12, 10,  8, 3'b000, 1, 1);
    send("or",  OP_OR,  12, 10, 14, 3'b000, 1, 1);

    // New ops
    send("xor", OP_XOR, 12, 10, 6, 3'b000, 1, 1);
    send("sll", OP_SLL, 1, 33, 2, 3'b000, 1, 1);
    send("srl", OP_SRL, 32'h8000_0000, 31, 1, 3'b000, 1, 1);
    send("slt", OP_SLT, 32'hFFFF_FFFF, 1, 1, 3'b000, 1, 1);

    // Flag corner cases
    send("add_wrap", OP_ADD, 32'hFFFF_FFFF, 1, 32'h0, 3'b110, 1, 1);
    send("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 1, 32'h8000_0000, 3'b001, 1, 1);
    send("sub_brw",  OP_SUB, 3, 5, 32'hFFFF_FFFE, 3'b010, 1, 1);
    drain("basic");

    // Backpressure: two accepts fill the pipe, then the input stalls
    out_ready = 1'b0;
    send("bp1", OP_ADD, 1, 1, 2, 3'b000, 0, 1);
    send("bp2", OP_ADD, 2, 2, 4, 3'b000, 0, 1);
    op_code = OP_ADD; operand_a = 3; operand_b = 3; in_valid = 1'b1;
    #1;
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_result", result, 2);
    repeat (3) @(negedge clk);
    #1;
    check("bp_in_ready_still_low", in_ready, 0);
    check("bp_out_valid_held", out_valid, 1);
    check("bp_result_stable", result, 2);
    @(negedge clk);
    out_ready = 1'b1;
    send("bp3", OP_ADD, 3, 3, 6, 3'b000, 0, 1);
    send("bp4", OP_ADD, 4, 4, 8, 3'b000, 0, 1);
    drain("bp");

    // Reset with both stages full
    out_ready = 1'b0;
    send("dropA", OP_ADD, 5, 5, 10, 3'b000, 0, 0);
    send("dropB", OP_ADD, 6, 6, 12, 3'b000, 0, 0);
    check("mid_full_before_rst", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send("post_rst", OP_ADD, 7, 8, 15, 3'b000, 1, 1);
    drain("post_rst");

    // WIDTH=8, STAGES=4: 200+100 wraps to 44 with carry, 4 cycles after presentation
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
    #1;
    check("w8_in_ready", ir8, 1);
    t0 = cyc;
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    n = 0;
    while (!ov8 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("w8_out_valid", ov8, 1);
    check("w8_latency", cyc - t0, 4);
    check("w8_result", r8, 44);
`ifdef PIPE_ALU_FLAGS_EN
    check("w8_flags", {fz8, fc8, fo8}, 3'b010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
